// File: rtl/dmem_lsu.sv
// Load/store unit: turns one byte/half/word core access into an aligned word
// access with byte enables, and formats load data coming back from a fixed-latency RAM.
module dmem_lsu #(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        off_q, off_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic [1:0]  req_size;
    logic [1:0]  req_off;
    logic        req_err;
    logic [3:0]  req_be;
    logic [31:0] req_wrep;
    logic        unused_addr_hi;

    // Byte-address bits above the word address never reach the RAM.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    function automatic logic [31:0] fmt_load(input logic [2:0]  typ,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
        logic [31:0] lane;
        lane = word >> {off, 3'b000};
        case (typ)
            3'b000:  fmt_load = {{24{lane[7]}}, lane[7:0]};
            3'b001:  fmt_load = {{16{lane[15]}}, lane[15:0]};
            3'b100:  fmt_load = {24'b0, lane[7:0]};
            3'b101:  fmt_load = {16'b0, lane[15:0]};
            default: fmt_load = word;
        endcase
    endfunction

    // Request decode: size is funct3[1:0] for both loads and stores.
    always_comb begin
        req_size = req_type[1:0];
        req_off  = req_addr[1:0];
        req_err  = (req_size == 2'b01 && req_off[0]) ||
                   (req_size == 2'b10 && req_off != 2'b00) ||
                   (req_size == 2'b11) ||
                   (!req_we && req_type[2:1] == 2'b11);
        case (req_size)
            2'b00:   req_be = 4'b0001 << req_off;
            2'b01:   req_be = req_off[1] ? 4'b1100 : 4'b0011;
            default: req_be = 4'b1111;
        endcase
        case (req_size)
            2'b00:   req_wrep = {4{req_wdata[7:0]}};
            2'b01:   req_wrep = {2{req_wdata[15:0]}};
            default: req_wrep = req_wdata;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        type_d       = type_q;
        off_d        = off_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_be_d     = '0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    type_d = req_type;
                    off_d  = req_off;
                    if (req_err) begin
                        state_d      = S_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d    = S_ACCESS;
                        mem_en_d   = 1'b1;
                        mem_we_d   = req_we;
                        mem_be_d   = req_be;
                        mem_addr_d = req_addr[ADDR_W+1:2];
                        if (req_we) begin
                            mem_wdata_d  = req_wrep;
                            resp_err_d   = 1'b0;
                            resp_rdata_d = '0;
                        end
                    end
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d      = S_RESP;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = fmt_load(type_q, off_q, mem_rdata);
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: reset is synchronous; a store already presented to the RAM still lands at the reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            type_q       <= '0;
            off_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            type_q       <= type_d;
            off_q        <= off_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // A store completes in its single ACCESS cycle; loads and errors respond from RESP.
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP) || (state_q == S_ACCESS && we_q);
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: two instances (MEM_LAT=1 and MEM_LAT=3) against a byte-array
// reference model, with directed cases followed by random traffic.
module tb_dmem_lsu;

    logic clk;
    logic reset;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [2:0]  req_type  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        resp_valid[2];
    logic        resp_err  [2];
    logic [31:0] resp_rdata[2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [3:0]  mem_be    [2];
    logic [9:0]  mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    logic [31:0] ram     [2][1024];
    logic [31:0] rd_pipe [2][4];
    logic [7:0]  ref_mem [2][4096];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_lsu #(.ADDR_W(10), .MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_type(req_type[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_err(resp_err[0]), .resp_rdata(resp_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    dmem_lsu #(.ADDR_W(10), .MEM_LAT(3)) u_dut_l3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_type(req_type[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_err(resp_err[1]), .resp_rdata(resp_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data appears MEM_LAT cycles after the sampling edge,
    // otherwise a poison pattern so mistimed captures are visible.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_en[d] && mem_we[d])
                for (int b = 0; b < 4; b++)
                    if (mem_be[d][b]) ram[d][mem_addr[d]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
            rd_pipe[d][0] <= (mem_en[d] && !mem_we[d]) ? ram[d][mem_addr[d]] : 32'hA5A5_5A5A;
            for (int i = 1; i < 4; i++) rd_pipe[d][i] <= rd_pipe[d][i-1];
        end
    end
    assign mem_rdata[0] = rd_pipe[0][0];
    assign mem_rdata[1] = rd_pipe[1][2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Transaction-level reference: legality, lane effects and load result.
    task automatic model_op(input int d, input logic we, input logic [2:0] typ,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic err, output logic [31:0] rdata,
                            output logic [3:0] be, output logic [31:0] wrep);
        int n;
        int a;
        logic [31:0] v;
        n = (typ[1:0] == 2'd0) ? 1 : (typ[1:0] == 2'd1) ? 2 : 4;
        if (we) err = (typ[1:0] == 2'b11);
        else    err = !(typ inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if ((int'(addr[1:0]) % n) != 0) err = 1'b1;
        a     = int'(addr[11:0]);
        be    = 4'(((1 << n) - 1) << addr[1:0]);
        wrep  = (n == 1) ? {4{wdata[7:0]}} : (n == 2) ? {2{wdata[15:0]}} : wdata;
        rdata = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[d][a+i] = wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[d][a+i];
                if (!typ[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
                if (!typ[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
                rdata = v;
            end
        end
    endtask

    task automatic wait_ready(input int d);
        int k;
        k = 0;
        while (!req_ready[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", 32'(req_ready[d]), 32'd1);
    endtask

    // Issues one request (entered and left on a falling edge) and checks it end to end.
    task automatic do_op(input int d, input logic we, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [3:0] o_be, output logic [31:0] o_wdata,
                         output logic [9:0] o_addr, output logic [31:0] o_rdata,
                         output logic o_err);
        logic        e_err;
        logic [31:0] e_rdata;
        logic [3:0]  e_be;
        logic [31:0] e_wrep;
        logic        got_we;
        int cyc, en_cnt, resp_cyc, exp_cyc;
        model_op(d, we, typ, addr, wdata, e_err, e_rdata, e_be, e_wrep);
        wait_ready(d);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_type[d]  = typ;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        @(negedge clk);
        req_valid[d] = 1'b0;
        cyc = 1; en_cnt = 0; resp_cyc = 0; got_we = 1'b0;
        o_be = '0; o_wdata = '0; o_addr = '0; o_rdata = '0; o_err = 1'b0;
        while (cyc <= 12 && resp_cyc == 0) begin
            if (mem_en[d]) begin
                en_cnt++;
                o_be = mem_be[d]; o_wdata = mem_wdata[d]; o_addr = mem_addr[d]; got_we = mem_we[d];
            end
            if (resp_valid[d]) begin
                resp_cyc = cyc; o_err = resp_err[d]; o_rdata = resp_rdata[d];
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        exp_cyc = (e_err || we) ? 1 : lat_of(d) + 2;
        check("resp_cycle", 32'(resp_cyc), 32'(exp_cyc));
        check("resp_err", 32'(o_err), 32'(e_err));
        check("resp_rdata", o_rdata, e_rdata);
        check("mem_en_count", 32'(en_cnt), e_err ? 32'd0 : 32'd1);
        if (!e_err) begin
            check("mem_we", 32'(got_we), 32'(we));
            check("mem_be", 32'(o_be), 32'(e_be));
            check("mem_addr", 32'(o_addr), 32'(addr[11:2]));
            if (we) check("mem_wdata", o_wdata, e_wrep);
        end
        @(negedge clk);
        check("resp_one_cycle", 32'(resp_valid[d]), 32'd0);
        check("ready_after", 32'(req_ready[d]), 32'd1);
        check("err_hold", 32'(resp_err[d]), 32'(e_err));
        check("rdata_hold", resp_rdata[d], e_rdata);
        check("mem_en_idle", 32'(mem_en[d]), 32'd0);
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_ready", 32'(req_ready[d]), 32'd1);
        check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
        check("rst_resp_err", 32'(resp_err[d]), 32'd0);
        check("rst_resp_rdata", resp_rdata[d], 32'd0);
        check("rst_mem_en", 32'(mem_en[d]), 32'd0);
        check("rst_mem_we", 32'(mem_we[d]), 32'd0);
        check("rst_mem_be", 32'(mem_be[d]), 32'd0);
        check("rst_mem_addr", 32'(mem_addr[d]), 32'd0);
        check("rst_mem_wdata", mem_wdata[d], 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  be;
        logic [31:0] wd, rd, e_rd;
        logic [9:0]  wa;
        logic        er, e_er;
        logic [3:0]  e_be;
        logic [31:0] e_wrep;
        int          resp_mask, ready_mask, pulses;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_type[d] = '0;
            req_addr[d] = '0; req_wdata[d] = '0;
        end
        // Reset with a store presented on instance 0: it must not be taken.
        reset = 1'b1;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_type[0] = 3'b010;
        req_addr[0] = 32'h10; req_wdata[0] = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check("reset_no_accept_en", 32'(mem_en[0]), 32'd0);
        check("reset_no_accept_rdy", 32'(req_ready[0]), 32'd1);
        req_valid[0] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);

        // Directed traffic on MEM_LAT=1.
        do_op(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, be, wd, wa, rd, er);
        check("sw_addr", 32'(wa), 32'd4);
        check("sw_be", 32'(be), 32'hF);
        do_op(0, 1'b0, 3'b010, 32'h10, 32'h0, be, wd, wa, rd, er);
        check("lw_rdata", rd, 32'hDEAD_BEEF);
        do_op(0, 1'b1, 3'b000, 32'h13, 32'h80, be, wd, wa, rd, er);
        check("sb_be", 32'(be), 32'h8);
        check("sb_wdata", wd, 32'h8080_8080);
        do_op(0, 1'b0, 3'b000, 32'h13, 32'h0, be, wd, wa, rd, er);
        check("lb_rdata", rd, 32'hFFFF_FF80);
        do_op(0, 1'b0, 3'b100, 32'h13, 32'h0, be, wd, wa, rd, er);
        check("lbu_rdata", rd, 32'h0000_0080);
        do_op(0, 1'b1, 3'b001, 32'h22, 32'h8001, be, wd, wa, rd, er);
        check("sh_be", 32'(be), 32'hC);
        do_op(0, 1'b0, 3'b001, 32'h22, 32'h0, be, wd, wa, rd, er);
        check("lh_rdata", rd, 32'hFFFF_8001);
        do_op(0, 1'b0, 3'b101, 32'h22, 32'h0, be, wd, wa, rd, er);
        check("lhu_rdata", rd, 32'h0000_8001);
        do_op(0, 1'b0, 3'b010, 32'h11, 32'h0, be, wd, wa, rd, er);
        check("lw_misalign_err", 32'(er), 32'd1);
        do_op(0, 1'b0, 3'b001, 32'h21, 32'h0, be, wd, wa, rd, er);
        check("lh_misalign_err", 32'(er), 32'd1);
        do_op(0, 1'b1, 3'b010, 32'h02, 32'h1234, be, wd, wa, rd, er);
        check("sw_misalign_err", 32'(er), 32'd1);
        do_op(0, 1'b0, 3'b011, 32'h10, 32'h0, be, wd, wa, rd, er);
        check("illegal_load_err", 32'(er), 32'd1);

        // Reset during the WAIT cycle of a load drops it.
        do_op(0, 1'b0, 3'b101, 32'h22, 32'h0, be, wd, wa, rd, er);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_type[0] = 3'b010; req_addr[0] = 32'h10;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs(0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid[0]) pulses++;
        end
        check("dropped_load_no_resp", 32'(pulses), 32'd0);
        do_op(0, 1'b0, 3'b010, 32'h10, 32'h0, be, wd, wa, rd, er);

        // MEM_LAT=3: two loads with req_valid held high.
        do_op(1, 1'b1, 3'b010, 32'h40, 32'h1234_5678, be, wd, wa, rd, er);
        model_op(1, 1'b0, 3'b010, 32'h40, 32'h0, e_er, e_rd, e_be, e_wrep);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_type[1] = 3'b010; req_addr[1] = 32'h40;
        resp_mask = 0; ready_mask = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (resp_valid[1]) begin
                resp_mask |= (1 << c);
                check("b2b_rdata", resp_rdata[1], e_rd);
            end
            if (req_ready[1]) ready_mask |= (1 << c);
            if (c == 7) req_valid[1] = 1'b0;
        end
        check("b2b_resp_cycles", 32'(resp_mask), 32'((1 << 5) | (1 << 11)));
        check("b2b_ready_cycles", 32'(ready_mask), 32'((1 << 6) | (1 << 12)));

        // Random traffic over a preloaded window, both latencies.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++)
                do_op(d, 1'b1, 3'b010, 32'h100 + 32'(4 * w), $urandom, be, wd, wa, rd, er);
            for (int k = 0; k < 60; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                do_op(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      32'h100 + 32'($urandom_range(0, 63)), $urandom, be, wd, wa, rd, er);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the `riscv` core's memory port and the word-organised data RAM. It accepts one byte, half-word or word access at a time and checks alignment. It converts the request into a word address, byte enables and replicated write data, and returns loads extracted and sign- or zero-extended. It adds a registered memory interface with a configurable read latency, so `dmem` can become a synchronous SRAM.

## Interface
- `ADDR_W`, 10: word-address width to memory; byte address bits `[ADDR_W+1:2]` are used and upper bits are ignored.
- `MEM_LAT`, 1: memory read latency in cycles, legal range 1..4.
- `clk` input 1: single clock; everything is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: core requests an access.
- `req_ready` output 1: LSU can accept a request; equals (state==IDLE).
- `req_we` input 1: 1 = store, 0 = load.
- `req_type` input 3: funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU. For stores only the low 2 bits are used.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_err` output 1: misaligned or illegal type; qualified by `resp_valid`.
- `resp_rdata` output 32: formatted load data; 0 for stores and errors.
- `mem_en` output 1: memory access strobe.
- `mem_we` output 1: write strobe.
- `mem_be` output 4: byte enables.
- `mem_addr` output ADDR_W: word address.
- `mem_wdata` output 32: lane-replicated write data.
- `mem_rdata` input 32: read word, valid `MEM_LAT` cycles after the edge that sampled `mem_en`.

## Operation
- **States:** IDLE, ACCESS, WAIT, RESP.
- **Accept:** a request is taken at an edge where `req_valid && req_ready`. Address, type and data are registered.
- **Error check:** an error is any of the following:
  - H/HU with `addr[0]=1`;
  - W with `addr[1:0]!=0`;
  - load type 011, 110 or 111;
  - store type with `req_type[1:0]=11`.
- **Error path:** IDLE goes to RESP. `resp_err=1`, `resp_rdata=0`, and no `mem_en` is issued.
- **Store path:** IDLE goes to ACCESS. In ACCESS: `mem_en=1`, `mem_we=1`, `resp_valid=1`, `resp_err=0`. The next state is IDLE.
- **Load path:** IDLE goes to ACCESS, where `mem_en=1` and `mem_we=0`. Then WAIT for exactly `MEM_LAT` cycles, counted by a down-counter. On the last WAIT cycle `mem_rdata` is captured and formatted. Then RESP, with `resp_valid=1`, then IDLE.
- **Byte enables:**
  - B: `mem_be = 4'b0001 << addr[1:0]`;
  - H: `addr[1]` selects 1100 vs 0011;
  - W: 1111;
  - loads use the same `mem_be`.
- **Write data:**
  - B: `{4{wdata[7:0]}}`;
  - H: `{2{wdata[15:0]}}`;
  - W: `wdata`.
- **Load format:** select the lane by `addr[1:0]`. Sign-extend B/H, zero-extend BU/HU; W passes through unchanged.
- **Memory outputs:** `mem_*` are registered. When `mem_en=0`, `mem_we`, `mem_be` and `mem_wdata` are 0.

## Timing
- Acceptance edge = E0; cycle n follows edge En-1.
- Store: `mem_en`/`mem_we` and `resp_valid` are all high in cycle 1. `req_ready` is high again in cycle 2.
- Load: `mem_en` is high in cycle 1. `resp_valid` is high in cycle `MEM_LAT+2`; for `MEM_LAT=1` that is cycle 3. `req_ready` is high in cycle `MEM_LAT+3`.
- Error: `resp_valid`/`resp_err` are high in cycle 1. `req_ready` is high in cycle 2.
- Throughput:
  - one store per 2 cycles;
  - one load per `MEM_LAT+3` cycles;
  - `req_valid` held while `req_ready=0` is not accepted and is not lost.
- `resp_valid` is exactly one cycle wide. There is no response back-pressure.
- `resp_rdata` and `resp_err` hold their values until the next response.
- Reset: after the reset edge, the state is IDLE and every output is 0 except `req_ready=1`. A load in flight is dropped with no `resp_valid`. A store whose ACCESS cycle coincides with reset still completes at that edge; no later write occurs.
- A request presented in the same cycle as `reset=1` is not accepted.

## Test plan
- **SW then LW, `MEM_LAT=1`:** store 0xDEADBEEF to 0x10, then load from 0x10.
  - Cycle 1: `mem_addr=4`, `mem_be=1111`.
  - Load: `resp_valid` in cycle 3 with `resp_rdata=0xDEADBEEF`.
- **SB then LB/LBU:** SB 0x80 to 0x13 gives `mem_be=1000`, `mem_wdata=0x80808080`. LB 0x13 returns 0xFFFFFF80; LBU 0x13 returns 0x00000080.
- **SH then LH:** SH 0x8001 to 0x22 gives `mem_be=1100`. LH 0x22 returns 0xFFFF8001; LHU returns 0x00008001.
- **Misaligned:** LW 0x11, LH 0x21 and SW 0x02 each give `resp_err=1` in cycle 1, `mem_en` never asserted, and `resp_rdata=0`.
- **`MEM_LAT=3`:** back-to-back loads with `req_valid` held high.
  - `resp_valid` in cycles 5 and 11 relative to the first acceptance.
  - `req_ready` low in between.
- **Reset mid-load:** assert `reset` in the WAIT cycle.
  - No `resp_valid` follows.
  - Outputs are 0 with `req_ready=1` in the next cycle.
  - A fresh LW then completes normally.
